// File: rtl/fir_fmt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_fmt_pkg
// Purpose  : Shared constants, types and helpers for the FIR output formatter.
//            round_t is wide enough for any supported input width plus one
//            guard bit, so the rounding add can never wrap.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fir_fmt_pkg;

  // Widest supported input sample; round_t carries one extra guard bit.
  localparam int RND_MAX_W = 64;

  typedef logic signed [RND_MAX_W:0] round_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Largest signed value representable in out_w bits.
  function automatic round_t sat_max(input int out_w);
    return (round_t'(1) <<< (out_w - 1)) - round_t'(1);
  endfunction

  // Smallest signed value representable in out_w bits.
  function automatic round_t sat_min(input int out_w);
    return -(round_t'(1) <<< (out_w - 1));
  endfunction

endpackage : fir_fmt_pkg
`default_nettype wire

// File: rtl/fir_fmt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fir_fmt_fifo
// Purpose  : First-word-fall-through FIFO; dout shows the head entry whenever
//            empty=0. A push while full is accepted only if a pop happens in
//            the same cycle, otherwise the pushed word is dropped.
// Ports    : clk, rst_n (sync, active-low), push/din, pop/dout,
//            full, empty, level (occupancy, 0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module fir_fmt_fifo
  import fir_fmt_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        din,
  input  logic                    pop,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == LVL_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop & ~empty;
  // Full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = push & (~full | w_do_pop);

  // Storage needs no reset: dout is only meaningful while empty=0.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign level = r_count;

endmodule : fir_fmt_fifo
`default_nettype wire

// File: rtl/fir_out_formatter.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_formatter
// Purpose  : Output stage of the 5-tap CSD FIR. Decimates, rounds yn right by
//            SHIFT bits, saturates to OUT_W bits and queues the result in an
//            FWFT FIFO with a valid/ready interface toward the DAC side.
//            Build option FIR_FMT_CONVERGENT_EN selects round-half-to-even;
//            otherwise rounding is round-half-up.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid, yn          - filter sample input (no backpressure)
//            out_data, out_valid,
//            out_ready             - output handshake (out_data 0 when idle)
//            ovf_sticky, overrun,
//            ovf_clr               - sticky saturation / drop flags + clear
//            level                 - FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module fir_out_formatter
  import fir_fmt_pkg::*;
#(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic signed [IN_W-1:0]        yn,
  output logic        [OUT_W-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          ovf_sticky,
  input  logic                          ovf_clr,
  output logic                          overrun,
  output logic [clog2(FIFO_DEPTH):0]    level
);

  localparam int     DCNT_W    = (DECIM > 1) ? clog2(DECIM) : 1;
  localparam round_t C_SAT_MAX = sat_max(OUT_W);
  localparam round_t C_SAT_MIN = sat_min(OUT_W);
  localparam round_t C_HALF    = round_t'(1) <<< (SHIFT - 1);

  // ---------------- decimation ----------------
  logic [DCNT_W-1:0] r_dcnt;
  logic              w_accept;

  assign w_accept = in_valid && (r_dcnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dcnt <= '0;
    end else if (in_valid) begin
      r_dcnt <= (r_dcnt == DCNT_W'(DECIM - 1)) ? '0 : r_dcnt + DCNT_W'(1);
    end
  end

  // ---------------- stage 1: rounding shift ----------------
  round_t w_ext;
  round_t w_bias;
  round_t w_sum;
  round_t w_rnd;

  always_comb begin
    w_ext = round_t'(yn);
`ifdef FIR_FMT_CONVERGENT_EN
    // Half minus one, plus the LSB that survives the shift: ties go to even.
    w_bias = C_HALF - round_t'(1) + round_t'(yn[SHIFT]);
`else
    w_bias = C_HALF;
`endif
    w_sum = w_ext + w_bias;
    w_rnd = w_sum >>> SHIFT;
  end

  logic   r_v1;
  round_t r_r1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_r1 <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) r_r1 <= w_rnd;
    end
  end

  // ---------------- stage 2: saturation + FIFO push ----------------
  logic             w_hi;
  logic             w_lo;
  logic [OUT_W-1:0] w_sat_data;

  assign w_hi = (r_r1 > C_SAT_MAX);
  assign w_lo = (r_r1 < C_SAT_MIN);

  always_comb begin
    w_sat_data = r_r1[OUT_W-1:0];
    if (w_hi) w_sat_data = C_SAT_MAX[OUT_W-1:0];
    if (w_lo) w_sat_data = C_SAT_MIN[OUT_W-1:0];
  end

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [OUT_W-1:0] w_fifo_dout;

  fir_fmt_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_v1),
    .din   (w_sat_data),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign out_data  = out_valid ? w_fifo_dout : '0;

  // ---------------- sticky status flags (set beats clear) ----------------
  logic w_ovf_set;
  logic w_ovr_set;
  logic r_ovf_sticky;
  logic r_overrun;

  assign w_ovf_set = r_v1 & (w_hi | w_lo);
  assign w_ovr_set = r_v1 & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_ovf_set)    r_ovf_sticky <= 1'b1;
      else if (ovf_clr) r_ovf_sticky <= 1'b0;
      if (w_ovr_set)    r_overrun    <= 1'b1;
      else if (ovf_clr) r_overrun    <= 1'b0;
    end
  end

  assign ovf_sticky = r_ovf_sticky;
  assign overrun    = r_overrun;

endmodule : fir_out_formatter
`default_nettype wire

// File: tb/tb_fir_out_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_out_formatter
// Purpose  : Directed self-checking bench for fir_out_formatter. One instance
//            uses DECIM=1 (rounding, saturation, FIFO), a second DECIM=3
//            (decimation and mid-stream reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_out_formatter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DECIM=1 instance
  logic        rst_n, in_valid, out_ready, ovf_clr;
  logic [31:0] yn;
  logic [15:0] out_data;
  logic        out_valid, ovf_sticky, overrun;
  logic [2:0]  level;

  // DECIM=3 instance
  logic        rst_n3, in_valid3, out_ready3, ovf_clr3;
  logic [31:0] yn3;
  logic [15:0] out_data3;
  logic        out_valid3, ovf_sticky3, overrun3;
  logic [2:0]  level3;

  fir_out_formatter #(.IN_W(32), .OUT_W(16), .SHIFT(15), .DECIM(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .yn(yn),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .overrun(overrun), .level(level)
  );

  fir_out_formatter #(.IN_W(32), .OUT_W(16), .SHIFT(15), .DECIM(3), .FIFO_DEPTH(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n3), .in_valid(in_valid3), .yn(yn3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .ovf_sticky(ovf_sticky3), .ovf_clr(ovf_clr3), .overrun(overrun3), .level(level3)
  );

`ifdef FIR_FMT_CONVERGENT_EN
  localparam logic [15:0] EXP_HALF_POS = 16'h0000;
`else
  localparam logic [15:0] EXP_HALF_POS = 16'h0001;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] q3[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_rec3();
    tick();
    if (out_valid3) q3.push_back(out_data3);
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  // Single sample with out_ready=1: invisible after one edge, valid after two.
  task automatic send_one(input string tag, input logic [31:0] v, input logic [15:0] exp);
    in_valid = 1'b1;
    yn       = v;
    tick();
    in_valid = 1'b0;
    yn       = '0;
    check({tag, "_early"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"},  64'(out_data),  64'(exp));
    tick();
    check({tag, "_popped"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; yn = '0; out_ready = 1'b1; ovf_clr = 1'b0;
    rst_n3 = 1'b0; in_valid3 = 1'b0; yn3 = '0; out_ready3 = 1'b1; ovf_clr3 = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_valid", 64'(out_valid),  64'd0);
    check("rst_data",  64'(out_data),   64'd0);
    check("rst_level", 64'(level),      64'd0);
    check("rst_ovf",   64'(ovf_sticky), 64'd0);
    check("rst_ovr",   64'(overrun),    64'd0);
    check("rst3_valid", 64'(out_valid3), 64'd0);
    rst_n  = 1'b1;
    rst_n3 = 1'b1;
    tick();

    // Rounding and latency: 1.5 LSB rounds to 2 in both builds
    send_one("basic", 32'h0000_C000, 16'h0002);
    send_one("half_pos", 32'h0000_4000, EXP_HALF_POS);
    send_one("half_neg", 32'hFFFF_C000, 16'h0000);
    check("no_ovf_yet", 64'(ovf_sticky), 64'd0);

    // Saturation
    send_one("sat_pos", 32'h3FFF_FFFF, 16'h7FFF);
    check("sat_pos_ovf", 64'(ovf_sticky), 64'd1);
    pulse_clr();
    check("clr1_ovf", 64'(ovf_sticky), 64'd0);
    send_one("sat_neg", 32'h8000_0000, 16'h8000);
    check("sat_neg_ovf", 64'(ovf_sticky), 64'd1);
    pulse_clr();
    check("clr2_ovf", 64'(ovf_sticky), 64'd0);
    send_one("sat_edge", 32'hC000_0000, 16'h8000);
    check("sat_edge_ovf", 64'(ovf_sticky), 64'd0);

    // Backpressure / overrun: 6 samples into a 4-deep FIFO
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      in_valid = 1'b1;
      yn       = 32'(k) << 15;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("bp_level", 64'(level),   64'd4);
    check("bp_ovr",   64'(overrun), 64'd1);
    check("bp_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("bp_data", 64'(out_data), 64'(k));
      tick();
    end
    check("bp_empty", 64'(out_valid), 64'd0);
    check("bp_level0", 64'(level), 64'd0);
    pulse_clr();
    check("bp_ovr_clr", 64'(overrun), 64'd0);

    // Full with simultaneous push and pop
    out_ready = 1'b0;
    for (int k = 10; k <= 14; k++) begin
      in_valid = 1'b1;
      yn       = 32'(k) << 15;
      tick();
    end
    check("pp_full_level", 64'(level), 64'd4);
    check("pp_full_ovr",   64'(overrun), 64'd0);
    out_ready = 1'b1;
    for (int k = 15; k <= 20; k++) begin
      yn = 32'(k) << 15;
      check("pp_data", 64'(out_data), 64'(k - 5));
      tick();
      check("pp_level", 64'(level), 64'd4);
    end
    in_valid = 1'b0;
    for (int j = 16; j <= 20; j++) begin
      check("pp_drain", 64'(out_data), 64'(j));
      tick();
    end
    check("pp_empty", 64'(out_valid), 64'd0);
    check("pp_ovr",   64'(overrun),   64'd0);

    // Decimation by 3 with reset one cycle after sample 6 is accepted
    for (int k = 0; k <= 8; k++) begin
      if (k == 7) rst_n3 = 1'b0;
      in_valid3 = 1'b1;
      yn3       = 32'(k) << 15;
      tick_rec3();
    end
    in_valid3 = 1'b0;
    check("dec_rst_valid", 64'(out_valid3), 64'd0);
    check("dec_rst_data",  64'(out_data3),  64'd0);
    check("dec_rst_level", 64'(level3),     64'd0);
    check("dec_count", 64'(q3.size()), 64'd2);
    check("dec_s0", 64'((q3.size() > 0) ? q3[0] : 16'hDEAD), 64'd0);
    check("dec_s1", 64'((q3.size() > 1) ? q3[1] : 16'hDEAD), 64'd3);
    rst_n3 = 1'b1;
    tick();
    q3.delete();
    for (int k = 9; k <= 11; k++) begin
      in_valid3 = 1'b1;
      yn3       = 32'(k) << 15;
      tick_rec3();
    end
    in_valid3 = 1'b0;
    for (int i = 0; i < 3; i++) tick_rec3();
    check("dec_restart_count", 64'(q3.size()), 64'd1);
    check("dec_restart_s0", 64'((q3.size() > 0) ? q3[0] : 16'hDEAD), 64'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fir_out_formatter
`default_nettype wire
